mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage pipeline. Sits between EX_MEM and MEM_WB and drives the writeback pair (wb_regDest/wb_result).

---
 rtl/mem_access_stage_pkg.sv | 52 +++++
 rtl/mem_access_stage_lane.sv | 57 +++++
 rtl/mem_access_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared encodings and helpers for the MEM stage
// Purpose: mem_op encodings, bus widths, FSM state encoding, byte-lane constants
//          and small decode helpers used by mem_access_stage and mem_lane_align.
// Ports:   none (package).
package mem_access_stage_pkg;

    localparam int WORD_BUS     = 32;
    localparam int REG_ADDR_BUS = 5;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LBU = 4'd2,
        OP_LH  = 4'd3,
        OP_LHU = 4'd4,
        OP_LW  = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= 4'(OP_LB)) && (op <= 4'(OP_SW));
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == 4'(OP_SB)) || (op == 4'(OP_SH)) || (op == 4'(OP_SW));
    endfunction

    // Byte ops are always aligned; anything that is not a memory op counts as aligned.
    function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] lo);
        logic ok;
        ok = 1'b1;
        if ((op == 4'(OP_LH)) || (op == 4'(OP_LHU)) || (op == 4'(OP_SH)))
            ok = ~lo[0];
        else if ((op == 4'(OP_LW)) || (op == 4'(OP_SW)))
            ok = (lo == 2'b00);
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_stage_lane.sv
// rtl/mem_access_stage_lane.sv - byte-lane steering for stores and load extraction
// Purpose: combinational store byte-enable / lane-replicated wdata generation and
//          load lane extraction with sign or zero extension.
// Ports:   st_op_i/st_lo_i/st_data_i -> byte_en_o, wdata_o   (store side, and load byteEn)
//          ld_op_i/ld_lo_i/rdata_i   -> ld_data_o            (load side)
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [3:0]          st_op_i,
    input  logic [1:0]          st_lo_i,
    input  logic [WORD_BUS-1:0] st_data_i,
    output logic [3:0]          byte_en_o,
    output logic [WORD_BUS-1:0] wdata_o,
    input  logic [3:0]          ld_op_i,
    input  logic [1:0]          ld_lo_i,
    input  logic [WORD_BUS-1:0] rdata_i,
    output logic [WORD_BUS-1:0] ld_data_o
);

    logic [WORD_BUS-1:0] shifted;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;

    // Lane enables depend only on access size, so loads and stores share them.
    always_comb begin
        byte_en_o = BE_NONE;
        wdata_o   = '0;
        case (st_op_i)
            OP_LB, OP_LBU, OP_SB: byte_en_o = BE_BYTE0 << st_lo_i;
            OP_LH, OP_LHU, OP_SH: byte_en_o = st_lo_i[1] ? BE_HI_HALF : BE_LO_HALF;
            OP_LW, OP_SW:         byte_en_o = BE_WORD;
            default:              byte_en_o = BE_NONE;
        endcase
        case (st_op_i)
            OP_SB:   wdata_o = {4{st_data_i[7:0]}};
            OP_SH:   wdata_o = {2{st_data_i[15:0]}};
            OP_SW:   wdata_o = st_data_i;
            default: wdata_o = '0;
        endcase
    end

    always_comb begin
        shifted   = rdata_i >> {ld_lo_i, 3'b000};
        ld_byte   = shifted[7:0];
        ld_half   = ld_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ld_data_o = '0;
        case (ld_op_i)
            OP_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data_o = {24'd0, ld_byte};
            OP_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data_o = {16'd0, ld_half};
            OP_LW:   ld_data_o = rdata_i;
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage with req/ack data bus and writeback
// Purpose: runs loads/stores on the data bus, stalls the front of the pipe while an
//          access is outstanding, and registers the writeback pair for all ops.
// Ports:   clk, rst (async, active-high)
//          mem_* : instruction from EX_MEM (valid, op, addr, storeData, regDest, result, writeEnable)
//          dbus_*: req/we/addr/byteEn/wdata out, ack/rdata in
//          wb_*  : valid, regDest, result, writeEnable to RegFile
//          stall (combinational), addrErr/badAddr misalignment report
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_valid,
    input  logic [3:0]              mem_op,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [WORD_W-1:0]       mem_storeData,
    input  logic [REG_ADDR_BUS-1:0] mem_regDest,
    input  logic [WORD_W-1:0]       mem_result,
    input  logic                    mem_writeEnable,
    output logic                    dbus_req,
    output logic                    dbus_we,
    output logic [ADDR_W-1:0]       dbus_addr,
    output logic [3:0]              dbus_byteEn,
    output logic [WORD_W-1:0]       dbus_wdata,
    input  logic                    dbus_ack,
    input  logic [WORD_W-1:0]       dbus_rdata,
    output logic                    wb_valid,
    output logic [REG_ADDR_BUS-1:0] wb_regDest,
    output logic [WORD_W-1:0]       wb_result,
    output logic                    wb_writeEnable,
    output logic                    stall,
    output logic                    addrErr,
    output logic [ADDR_W-1:0]       badAddr
);

    state_e                  state_q;
    logic [3:0]              op_q;
    logic [1:0]              lo_q;
    logic [REG_ADDR_BUS-1:0] dest_q;
    logic                    req_q, we_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [3:0]              be_q;
    logic [WORD_W-1:0]       wdata_q;
    logic                    wb_valid_q, wb_we_q, addr_err_q;
    logic [REG_ADDR_BUS-1:0] wb_dest_q;
    logic [WORD_W-1:0]       wb_result_q;
    logic [ADDR_W-1:0]       bad_addr_q;

    logic                    in_mem, in_aligned;
    logic [3:0]              st_be;
    logic [WORD_W-1:0]       st_wdata, ld_data;

    assign in_mem     = mem_valid && is_mem_op(mem_op);
    assign in_aligned = is_aligned(mem_op, mem_addr[1:0]);

    // Store lanes are computed from the live inputs at accept time; load
    // extraction uses the latched op/offset against the acked read word.
    mem_lane_align u_lane (
        .st_op_i   (mem_op),
        .st_lo_i   (mem_addr[1:0]),
        .st_data_i (mem_storeData),
        .byte_en_o (st_be),
        .wdata_o   (st_wdata),
        .ld_op_i   (op_q),
        .ld_lo_i   (lo_q),
        .rdata_i   (dbus_rdata),
        .ld_data_o (ld_data)
    );

    // Drops in the ack cycle so EX_MEM advances on the edge that returns us to IDLE.
    assign stall = ((state_q == ST_IDLE) && in_mem && in_aligned) ||
                   ((state_q == ST_BUSY) && !dbus_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 4'(OP_NOP);
            lo_q        <= 2'b00;
            dest_q      <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= BE_NONE;
            wdata_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_dest_q   <= '0;
            wb_result_q <= '0;
            addr_err_q  <= 1'b0;
            bad_addr_q  <= '0;
        end else begin
            addr_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_mem && in_aligned) begin
                        state_q    <= ST_BUSY;
                        op_q       <= mem_op;
                        lo_q       <= mem_addr[1:0];
                        dest_q     <= mem_regDest;
                        req_q      <= 1'b1;
                        we_q       <= is_store(mem_op);
                        addr_q     <= {mem_addr[ADDR_W-1:2], 2'b00};
                        be_q       <= st_be;
                        wdata_q    <= st_wdata;
                        wb_valid_q <= 1'b0;
                        wb_we_q    <= 1'b0;
                    end else if (in_mem) begin
                        // Misaligned: retire without a bus access or register write.
                        wb_valid_q  <= 1'b1;
                        wb_we_q     <= 1'b0;
                        wb_dest_q   <= mem_regDest;
                        wb_result_q <= '0;
                        addr_err_q  <= 1'b1;
                        bad_addr_q  <= mem_addr;
                    end else if (mem_valid) begin
                        wb_valid_q  <= 1'b1;
                        wb_we_q     <= mem_writeEnable;
                        wb_dest_q   <= mem_regDest;
                        wb_result_q <= mem_result;
                    end else begin
                        wb_valid_q <= 1'b0;
                        wb_we_q    <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    wb_valid_q <= 1'b0;
                    wb_we_q    <= 1'b0;
                    if (dbus_ack) begin
                        state_q    <= ST_IDLE;
                        req_q      <= 1'b0;
                        we_q       <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_dest_q  <= dest_q;
                        if (is_store(op_q)) begin
                            wb_we_q     <= 1'b0;
                            wb_result_q <= '0;
                        end else begin
                            wb_we_q     <= 1'b1;
                            wb_result_q <= ld_data;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dbus_req       = req_q;
    assign dbus_we        = we_q;
    assign dbus_addr      = addr_q;
    assign dbus_byteEn    = be_q;
    assign dbus_wdata     = wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_regDest     = wb_dest_q;
    assign wb_result      = wb_result_q;
    assign wb_writeEnable = wb_we_q;
    assign addrErr        = addr_err_q;
    assign badAddr        = bad_addr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed scoreboard bench for mem_access_stage
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [3:0]  mem_op = 4'd0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_storeData = '0;
    logic [4:0]  mem_regDest = '0;
    logic [31:0] mem_result = '0;
    logic        mem_writeEnable = 1'b0;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_byteEn;
    logic        dbus_ack = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic        wb_valid, wb_writeEnable, stall, addrErr;
    logic [4:0]  wb_regDest;
    logic [31:0] wb_result, badAddr;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] res;
        logic        we;
        logic        ae;
        logic [31:0] bad;
        logic        chk_res;
    } wb_t;

    wb_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(32), .WORD_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_storeData(mem_storeData), .mem_regDest(mem_regDest),
        .mem_result(mem_result), .mem_writeEnable(mem_writeEnable),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_byteEn(dbus_byteEn), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .wb_valid(wb_valid), .wb_regDest(wb_regDest), .wb_result(wb_result),
        .wb_writeEnable(wb_writeEnable), .stall(stall),
        .addrErr(addrErr), .badAddr(badAddr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every writeback must match the oldest expectation.
    always @(negedge clk) begin
        wb_t e;
        if (!rst && wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_regDest", 32'(wb_regDest), 32'(e.dest));
                check("wb_writeEnable", 32'(wb_writeEnable), 32'(e.we));
                check("wb_addrErr", 32'(addrErr), 32'(e.ae));
                if (e.ae) check("wb_badAddr", badAddr, e.bad);
                if (e.chk_res) check("wb_result", wb_result, e.res);
            end
        end
    end

    task automatic push_exp(input logic [4:0] dest, input logic [31:0] res, input logic we,
                            input logic ae, input logic [31:0] bad, input logic chk_res);
        wb_t e;
        e.dest = dest; e.res = res; e.we = we; e.ae = ae; e.bad = bad; e.chk_res = chk_res;
        exp_q.push_back(e);
    endtask

    // One aligned memory access with ack after 'delay' request cycles.
    task automatic do_mem(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] dest, input int delay,
                          input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_res);
        logic st;
        st = is_store(op);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_op = op; mem_addr = addr; mem_storeData = sdata;
        mem_regDest = dest; mem_result = 32'hBAD0_0000; mem_writeEnable = ~st;
        push_exp(dest, exp_res, ~st, 1'b0, 32'd0, ~st);
        @(negedge clk);
        check({tag, "_accept_stall"}, 32'(stall), 32'd1);
        check({tag, "_accept_noreq"}, 32'(dbus_req), 32'd0);
        @(posedge clk); #1;
        // Disturb the held EX_MEM contents; the latched copy must be used.
        mem_addr = ~addr; mem_storeData = ~sdata; mem_op = st ? 4'(OP_LB) : 4'(OP_SW);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check({tag, "_wait_req"}, 32'(dbus_req), 32'd1);
            check({tag, "_wait_stall"}, 32'(stall), 32'd1);
            @(posedge clk); #1;
        end
        dbus_ack = 1'b1; dbus_rdata = rdata;
        @(negedge clk);
        check({tag, "_req"}, 32'(dbus_req), 32'd1);
        check({tag, "_we"}, 32'(dbus_we), 32'(st));
        check({tag, "_addr"}, dbus_addr, addr & 32'hFFFF_FFFC);
        check({tag, "_byteEn"}, 32'(dbus_byteEn), 32'(exp_be));
        if (st) check({tag, "_wdata"}, dbus_wdata, exp_wd);
        check({tag, "_ack_stall"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        dbus_ack = 1'b0; dbus_rdata = 32'h5A5A_5A5A; mem_valid = 1'b0;
        @(negedge clk); #1;
        check({tag, "_wb_seen"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_req_drop"}, 32'(dbus_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_req", 32'(dbus_req), 32'd0);
        check("rst_we", 32'(dbus_we), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_we", 32'(wb_writeEnable), 32'd0);
        check("rst_addrErr", 32'(addrErr), 32'd0);
        check("rst_dbus_addr", dbus_addr, 32'd0);
        check("rst_wb_result", wb_result, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        do_mem("lw",  4'(OP_LW),  32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
        do_mem("lb",  4'(OP_LB),  32'h103, 32'h0, 5'd6, 0, 32'h80123456, 4'b1000, 32'h0, 32'hFFFFFF80);
        do_mem("lbu", 4'(OP_LBU), 32'h103, 32'h0, 5'd7, 0, 32'h80123456, 4'b1000, 32'h0, 32'h00000080);
        do_mem("lh",  4'(OP_LH),  32'h102, 32'h0, 5'd8, 0, 32'h80017F00, 4'b1100, 32'h0, 32'hFFFF8001);
        do_mem("lhu", 4'(OP_LHU), 32'h100, 32'h0, 5'd9, 1, 32'h1234ABCD, 4'b0011, 32'h0, 32'h0000ABCD);
        do_mem("sb",  4'(OP_SB),  32'h101, 32'h00000012, 5'd10, 0, 32'h0, 4'b0010, 32'h12121212, 32'h0);
        do_mem("sh",  4'(OP_SH),  32'h202, 32'hCAFE5678, 5'd11, 2, 32'h0, 4'b1100, 32'h56785678, 32'h0);
        do_mem("sw",  4'(OP_SW),  32'h300, 32'h01020304, 5'd12, 0, 32'h0, 4'b1111, 32'h01020304, 32'h0);

        // Misaligned word load: no bus access, one-cycle addrErr, no stall
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_op = 4'(OP_LW); mem_addr = 32'h102; mem_regDest = 5'd13; mem_writeEnable = 1'b1;
        push_exp(5'd13, 32'h0, 1'b0, 1'b1, 32'h102, 1'b0);
        @(negedge clk);
        check("misal_stall", 32'(stall), 32'd0);
        check("misal_noreq", 32'(dbus_req), 32'd0);
        @(posedge clk); #1 mem_valid = 1'b0;
        @(negedge clk);
        check("misal_addrErr", 32'(addrErr), 32'd1);
        check("misal_noreq2", 32'(dbus_req), 32'd0);
        #1 check("misal_wb_seen", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("misal_pulse_end", 32'(addrErr), 32'd0);
        check("misal_wb_single", 32'(wb_valid), 32'd0);

        // Spurious ack while idle is ignored
        @(posedge clk); #1 dbus_ack = 1'b1;
        @(negedge clk);
        check("spur_noreq", 32'(dbus_req), 32'd0);
        check("spur_stall", 32'(stall), 32'd0);
        @(posedge clk); #1 dbus_ack = 1'b0;
        @(negedge clk);
        check("spur_nowb", 32'(wb_valid), 32'd0);
        do_mem("lw_slow", 4'(OP_LW), 32'h104, 32'h0, 5'd14, 5, 32'h13579BDF, 4'b1111, 32'h0, 32'h13579BDF);
        @(negedge clk);
        check("lw_slow_single_wb", 32'(wb_valid), 32'd0);

        // Back-to-back non-memory ops pass straight through
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_op = 4'(OP_NOP); mem_result = 32'h0000_0011; mem_regDest = 5'd3; mem_writeEnable = 1'b1;
        push_exp(5'd3, 32'h11, 1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("add1_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        mem_result = 32'hFEDC_BA98; mem_regDest = 5'd0; mem_writeEnable = 1'b0;
        push_exp(5'd0, 32'hFEDCBA98, 1'b0, 1'b0, 32'h0, 1'b1);
        @(posedge clk); #1 mem_valid = 1'b0;
        @(negedge clk); #1;
        check("add_wb_seen", 32'(exp_q.size()), 32'd0);

        // Reset while BUSY abandons the access
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_op = 4'(OP_LW); mem_addr = 32'h400; mem_regDest = 5'd15;
        @(posedge clk); #1 mem_valid = 1'b0;
        @(negedge clk);
        check("rstbusy_req", 32'(dbus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstbusy_req_drop", 32'(dbus_req), 32'd0);
        check("rstbusy_stall", 32'(stall), 32'd0);
        check("rstbusy_wb", 32'(wb_valid), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstbusy_idle_req", 32'(dbus_req), 32'd0);
        check("rstbusy_idle_wb", 32'(wb_valid), 32'd0);
        do_mem("lw_after_rst", 4'(OP_LW), 32'h400, 32'h0, 5'd15, 1, 32'hA5A50F0F, 4'b1111, 32'h0, 32'hA5A50F0F);

        @(posedge clk);
        @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
